// File: rtl/veda_pkg.sv
// Shared constants and types for the veda core memory subsystem.
package veda_pkg;

    localparam int VEDA_ADDR_W    = 6;
    localparam int VEDA_DATA_W    = 32;
    localparam int VEDA_IMEM_BASE = 32;

    // Load/store opcodes, also decoded by the core.
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    // Which requester owns the read currently in flight.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } arb_owner_t;

    // Response state: ST_RD means a read returns data this cycle.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RD   = 1'b1
    } arb_state_t;

endpackage

// File: rtl/veda_starve_cnt.sv
// Fetch starvation counter: counts consecutive cycles in which fetch is
// pending but loses to load/store, and forces a fetch win once the count
// reaches STARVE_MAX (legal range 1..15).
module veda_starve_cnt
    import veda_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic if_gnt,
    input  logic ls_gnt,
    output logic force_if
);

    localparam logic [3:0] MAX_C = 4'(STARVE_MAX);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count: clear on fetch progress or no fetch demand, else count a loss.
    always_comb begin
        cnt_d = cnt_q;
        if (!if_req || if_gnt) begin
            cnt_d = 4'd0;
        end else if (ls_gnt && (cnt_q < MAX_C)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_if = (cnt_q == MAX_C);

endmodule

// File: rtl/veda_mem_arbiter.sv
// Two-requester arbiter for the single-port 64x32 veda memory. Load/store
// normally wins; the starvation counter guarantees fetch progress. Read data
// is routed back to whichever requester owned the read, and load/store
// writes into the instruction region are dropped with an error pulse.
module veda_mem_arbiter
    import veda_pkg::*;
#(
    parameter int ADDR_W     = VEDA_ADDR_W,
    parameter int DATA_W     = VEDA_DATA_W,
    parameter int IMEM_BASE  = VEDA_IMEM_BASE,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] IMEM_BASE_A = ADDR_W'(IMEM_BASE);

    logic       force_if;
    logic       ls_prot;
    arb_owner_t owner_q;
    arb_state_t state_q;
    logic       ls_err_q;

    veda_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_gnt   (if_gnt),
        .ls_gnt   (ls_gnt),
        .force_if (force_if)
    );

    // Grants are combinational and held off entirely during reset.
    assign if_gnt = rst_n & if_req & (~ls_req | force_if);
    assign ls_gnt = rst_n & ls_req & ~(if_req & force_if);

    // Stores at or above the instruction base are granted but never written.
    assign ls_prot   = (ls_addr >= IMEM_BASE_A);
    assign mem_en    = if_gnt | ls_gnt;
    assign mem_we    = ls_gnt & ls_we & ~ls_prot;
    assign mem_addr  = if_gnt ? if_addr : ls_addr;
    assign mem_wdata = if_gnt ? '0 : ls_wdata;

    // Response FSM: record the owner of each granted read; a new grant is
    // accepted in ST_RD so back-to-back reads return one word per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_NONE;
            ls_err_q <= 1'b0;
        end else begin
            ls_err_q <= ls_gnt & ls_we & ls_prot;
            if (if_gnt) begin
                state_q <= ST_RD;
                owner_q <= OWN_IF;
            end else if (ls_gnt && !ls_we) begin
                state_q <= ST_RD;
                owner_q <= OWN_LS;
            end else begin
                state_q <= ST_IDLE;
                owner_q <= OWN_NONE;
            end
        end
    end

    assign if_rvalid = (state_q == ST_RD) && (owner_q == OWN_IF);
    assign ls_rvalid = (state_q == ST_RD) && (owner_q == OWN_LS);
    assign ls_err    = ls_err_q;

    // Read data is only presented to the requester that owns it.
    assign if_rdata = if_rvalid ? mem_rdata : '0;
    assign ls_rdata = ls_rvalid ? mem_rdata : '0;

endmodule
